// File: rtl/prog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_pkg
// Description : Shared types and constants for the program loader/encoder:
//               mnemonic enumeration, opcode/funct fields, error codes and
//               FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_pkg;

  // Symbolic mnemonics presented by the host; values 16..31 are illegal
  typedef enum logic [4:0] {
    M_ADD  = 5'd0,
    M_SUB  = 5'd1,
    M_LDR  = 5'd2,
    M_STR  = 5'd3,
    M_LDI  = 5'd4,
    M_STI  = 5'd5,
    M_ALUI = 5'd6,
    M_BR   = 5'd7,
    M_MOV  = 5'd8,
    M_LSL  = 5'd9,
    M_ASR  = 5'd10,
    M_LSR  = 5'd11,
    M_NOT  = 5'd12,
    M_AND  = 5'd13,
    M_OR   = 5'd14,
    M_MUL  = 5'd15
  } mnem_t;

  // Opcode field, word bits [8:6]
  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LDI   = 3'b001;
  localparam logic [2:0] OP_STI   = 3'b010;
  localparam logic [2:0] OP_ALUI  = 3'b011;
  localparam logic [2:0] OP_BR    = 3'b100;
  localparam logic [2:0] OP_MOV   = 3'b101;
  localparam logic [2:0] OP_SHIFT = 3'b110;
  localparam logic [2:0] OP_LOGIC = 3'b111;

  // Funct field, word bits [5:4], for register-form opcodes
  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_LDR = 2'b10;
  localparam logic [1:0] FN_STR = 2'b11;
  localparam logic [1:0] FN_LSL = 2'b00;
  localparam logic [1:0] FN_ASR = 2'b01;
  localparam logic [1:0] FN_LSR = 2'b10;
  localparam logic [1:0] FN_NOT = 2'b11;
  localparam logic [1:0] FN_AND = 2'b00;
  localparam logic [1:0] FN_OR  = 2'b01;
  localparam logic [1:0] FN_MUL = 2'b10;

  // Sticky error codes
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;

  // Loader FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WRITE = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_ERR   = 3'd5;

endpackage : prog_pkg
`default_nettype wire

// File: rtl/prog_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_encoder_if
// Description : Valid/ready instruction stream from the boot/test host to the
//               encoder. master = host side, slave = encoder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_encoder_if;

  logic       s_valid;
  logic       s_ready;
  logic [4:0] s_mnem;
  logic [3:0] s_reg;
  logic [5:0] s_imm;
  logic       s_dst;

  modport master (
    output s_valid,
    output s_mnem,
    output s_reg,
    output s_imm,
    output s_dst,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_mnem,
    input  s_reg,
    input  s_imm,
    input  s_dst,
    output s_ready
  );

endinterface : prog_encoder_if
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Purely combinational packer from a symbolic instruction
//               (mnemonic + operand fields) to the 9-bit machine word.
//               Flags mnemonics that have no encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
  import prog_pkg::*;
(
  input  wire logic [4:0] mnem,
  input  wire logic [3:0] rsel,
  input  wire logic [5:0] imm,
  input  wire logic       dst,
  output logic      [8:0] word,
  output logic            illegal
);

  // Map each mnemonic onto its opcode/funct/operand layout; unused operands
  // are simply not placed into the word
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (mnem)
      M_ADD:   word = {OP_RTYPE, FN_ADD, rsel};
      M_SUB:   word = {OP_RTYPE, FN_SUB, rsel};
      M_LDR:   word = {OP_RTYPE, FN_LDR, rsel};
      M_STR:   word = {OP_RTYPE, FN_STR, rsel};
      M_LDI:   word = {OP_LDI, imm};
      M_STI:   word = {OP_STI, imm};
      M_ALUI:  word = {OP_ALUI, imm};
      M_BR:    word = {OP_BR, imm};
      // MOV carries the destination select in bit 5 and the source register
      // one position up, leaving bit 0 clear
      M_MOV:   word = {OP_MOV, dst, rsel, 1'b0};
      M_LSL:   word = {OP_SHIFT, FN_LSL, rsel};
      M_ASR:   word = {OP_SHIFT, FN_ASR, rsel};
      M_LSR:   word = {OP_SHIFT, FN_LSR, rsel};
      M_NOT:   word = {OP_SHIFT, FN_NOT, rsel};
      M_AND:   word = {OP_LOGIC, FN_AND, rsel};
      M_OR:    word = {OP_LOGIC, FN_OR, rsel};
      M_MUL:   word = {OP_LOGIC, FN_MUL, rsel};
      default: illegal = 1'b1;
    endcase
  end

endmodule : instr_pack
`default_nettype wire

// File: rtl/prog_encoder.sv
`default_nettype none
// ============================================================================
// Module      : prog_encoder
// Description : Program loader. Accepts symbolic instructions, encodes them,
//               writes them sequentially into instruction memory and verifies
//               each write by reading it back. Illegal mnemonics and readback
//               mismatches park the loader in a sticky error state.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_encoder
  import prog_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  prog_encoder_if.slave          s,
  input  wire logic              finish,
  output logic                   im_we,
  output logic                   im_re,
  output logic      [ADDR_W-1:0] im_addr,
  output logic      [8:0]        im_wdata,
  input  wire logic [8:0]        im_rdata,
  output logic      [ADDR_W:0]   count,
  output logic                   full,
  output logic                   done,
  output logic                   err,
  output logic      [1:0]        err_code
);

  localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W:0]   r_count;
  logic [8:0]        r_word;
  logic [1:0]        r_err_code;

  logic [8:0]        w_word;
  logic              w_illegal;
  logic              w_full;
  logic              w_ready;
  logic              w_accept;
  logic              w_match;

  instr_pack u_pack (
    .mnem    (s.s_mnem),
    .rsel    (s.s_reg),
    .imm     (s.s_imm),
    .dst     (s.s_dst),
    .word    (w_word),
    .illegal (w_illegal)
  );

  // Handshake and status decode; count never exceeds DEPTH so full is exact
  always_comb begin
    w_full   = (r_count == c_DEPTH);
    w_ready  = (r_state == ST_IDLE) && !w_full;
    w_accept = s.s_valid && w_ready;
    w_match  = (im_rdata == r_word);
  end

  // Loader FSM: one instruction is accept -> write -> read -> check
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_word     <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // An incoming instruction wins over finish in the same cycle
          if (w_accept) begin
            if (w_illegal) begin
              r_state    <= ST_ERR;
              r_err_code <= ERR_ILLEGAL;
            end else begin
              r_word  <= w_word;
              r_state <= ST_WRITE;
            end
          end else if (finish) begin
            r_state <= ST_DONE;
          end
        end
        ST_WRITE: r_state <= ST_READ;
        ST_READ:  r_state <= ST_CHECK;
        ST_CHECK: begin
          // Only a verified word advances the write pointer
          if (w_match) begin
            r_count <= r_count + c_ONE;
            r_state <= ST_IDLE;
          end else begin
            r_err_code <= ERR_MISMATCH;
            r_state    <= ST_ERR;
          end
        end
        ST_DONE:  r_state <= ST_DONE;
        ST_ERR:   r_state <= ST_ERR;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory strobes are decoded from state, so each is a single-cycle pulse;
  // the address follows the verified count and therefore never wraps
  always_comb begin
    im_we    = (r_state == ST_WRITE);
    im_re    = (r_state == ST_READ);
    im_addr  = r_count[ADDR_W-1:0];
    im_wdata = r_word;
  end

  assign s.s_ready = w_ready;
  assign count     = r_count;
  assign full      = w_full;
  assign done      = (r_state == ST_DONE);
  assign err       = (r_state == ST_ERR);
  assign err_code  = r_err_code;

endmodule : prog_encoder
`default_nettype wire
